// File: rtl/core_pkg.sv
// Shared core definitions used by the fetch front end and by decode.
//   DWIDTH           : instruction / address width
//   PC_STEP          : byte distance between consecutive instructions
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_pkt_t      : {instr, pc} packet handed from fetch to decode
package core_pkg;

   localparam int unsigned DWIDTH = 32;
   localparam logic [31:0] PC_STEP = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and decode.
//   imem_enable/imem_address/imem_instruction : synchronous 1-cycle-latency memory port
//   redirect_valid/redirect_pc                : one-cycle restart request
//   inst_valid/inst_ready/inst_out/inst_pc    : valid/ready handshake to decode
// modport master : fetch unit side
// modport slave  : memory + decode side
interface fetch_unit_if #(
   parameter int unsigned DWIDTH = 32
) ();

   logic              imem_enable;
   logic [DWIDTH-1:0] imem_address;
   logic [DWIDTH-1:0] imem_instruction;
   logic              redirect_valid;
   logic [DWIDTH-1:0] redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [DWIDTH-1:0] inst_out;
   logic [DWIDTH-1:0] inst_pc;

   modport master (
      output imem_enable,
      output imem_address,
      input  imem_instruction,
      input  redirect_valid,
      input  redirect_pc,
      output inst_valid,
      input  inst_ready,
      output inst_out,
      output inst_pc
   );

   modport slave (
      input  imem_enable,
      input  imem_address,
      output imem_instruction,
      output redirect_valid,
      output redirect_pc,
      input  inst_valid,
      output inst_ready,
      input  inst_out,
      input  inst_pc
   );

endinterface

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetch packets.
//   clk, reset : clock, asynchronous active-high reset
//   i_push     : write i_push_pkt at the clock edge
//   i_pop      : drop the head at the clock edge (caller only pops when non-empty)
//   i_flush    : empty the FIFO; overrides push and pop
//   o_head     : head packet, all zeros when empty
//   o_count    : number of stored entries
module fetch_buffer
   import core_pkg::*;
#(
   parameter int unsigned BUF_DEPTH = 2,
   localparam int unsigned PTR_W = $clog2(BUF_DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  fetch_pkt_t       i_push_pkt,
   input  logic             i_pop,
   input  logic             i_flush,
   output fetch_pkt_t       o_head,
   output logic [CNT_W-1:0] o_count
);

   fetch_pkt_t       r_mem [BUF_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Depth is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         unique case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_pkt;
   end

   assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues reads to a 1-cycle synchronous
// instruction memory, queues returned {instr, pc} in fetch_buffer and presents the
// head to decode. A redirect flushes the buffer and drops the fetch in flight.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : fetch_unit_if.master (memory port, redirect, decode handshake)
module fetch_unit #(
   parameter int unsigned DWIDTH    = core_pkg::DWIDTH,
   parameter int unsigned BUF_DEPTH = 2,
   parameter logic [31:0] RESET_PC  = core_pkg::RESET_PC_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master bus
);
   import core_pkg::*;

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

   logic [DWIDTH-1:0] r_fetch_pc;
   logic [DWIDTH-1:0] r_inflight_pc;
   logic              r_inflight;

   fetch_pkt_t        w_head;
   fetch_pkt_t        w_push_pkt;
   logic [CNT_W-1:0]  w_count;
   logic [CNT_W:0]    w_occupancy;
   logic              w_pop;
   logic              w_issue;
   logic              w_push;

   assign w_pop = bus.inst_valid && bus.inst_ready;

   // Credits: buffered entries plus the word still in flight never exceed the depth,
   // except that a pop this cycle frees a slot for the word issued now.
   assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
   assign w_issue = !reset && !bus.redirect_valid &&
                    ((w_occupancy < (CNT_W + 1)'(BUF_DEPTH)) || w_pop);

   // The returning word is wrong-path if a redirect arrives in its capture cycle.
   assign w_push     = r_inflight && !bus.redirect_valid;
   assign w_push_pkt = '{instr: bus.imem_instruction, pc: r_inflight_pc};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else begin
         r_inflight <= w_issue;
         if (bus.redirect_valid) begin
            r_fetch_pc <= {bus.redirect_pc[DWIDTH-1:2], 2'b00};
         end else if (w_issue) begin
            r_fetch_pc    <= r_fetch_pc + PC_STEP;
            r_inflight_pc <= r_fetch_pc;
         end
      end
   end

   fetch_buffer #(
      .BUF_DEPTH (BUF_DEPTH)
   ) u_fetch_buffer (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push),
      .i_push_pkt (w_push_pkt),
      .i_pop      (w_pop),
      .i_flush    (bus.redirect_valid),
      .o_head     (w_head),
      .o_count    (w_count)
   );

   assign bus.imem_enable  = w_issue;
   assign bus.imem_address = r_fetch_pc;
   assign bus.inst_valid   = (w_count != '0);
   assign bus.inst_out     = w_head.instr;
   assign bus.inst_pc      = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances share clock and reset. u_dut0 (RESET_PC 0)
// is stimulated step by step; u_dut1 (RESET_PC FFFF_FFF8) streams with ready held high.
module tb_fetch_unit;

   logic clk;
   logic reset;

   fetch_unit_if #(.DWIDTH(32)) bus0 ();
   fetch_unit_if #(.DWIDTH(32)) bus1 ();

   fetch_unit #(
      .DWIDTH    (32),
      .BUF_DEPTH (2),
      .RESET_PC  (32'h0000_0000)
   ) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   fetch_unit #(
      .DWIDTH    (32),
      .BUF_DEPTH (2),
      .RESET_PC  (32'hFFFF_FFF8)
   ) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory image: first four words are the program, the rest are tagged with their index.
   function automatic logic [31:0] mem_word(input logic [5:0] idx);
      case (idx)
         6'd0:    return 32'h00E0_0093;
         6'd1:    return 32'h0010_0113;
         6'd2:    return 32'h0010_0193;
         6'd3:    return 32'h0010_0313;
         default: return 32'hA000_0000 | {26'd0, idx};
      endcase
   endfunction

   logic [31:0] r_rdata0;
   logic [31:0] r_rdata1;

   // Synchronous memories: 1-cycle latency, output held when not enabled.
   always @(posedge clk) begin
      if (bus0.imem_enable) r_rdata0 <= mem_word(bus0.imem_address[7:2]);
      if (bus1.imem_enable) r_rdata1 <= mem_word(bus1.imem_address[7:2]);
   end

   assign bus0.imem_instruction = r_rdata0;
   assign bus1.imem_instruction = r_rdata1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Move to 2 time units after the next rising edge; inputs are set there, checks 1 later.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
      check({tag, "_valid"}, {31'd0, bus0.inst_valid}, 32'd1);
      check({tag, "_pc"}, bus0.inst_pc, pc);
      check({tag, "_out"}, bus0.inst_out, ins);
   endtask

   task automatic expect_issue(input string tag, input logic en, input logic [31:0] addr);
      check({tag, "_en"}, {31'd0, bus0.imem_enable}, {31'd0, en});
      if (en) check({tag, "_addr"}, bus0.imem_address, addr);
   endtask

   task automatic expect_wrap(input string tag, input logic [31:0] pc, input logic [31:0] ins);
      check({tag, "_valid"}, {31'd0, bus1.inst_valid}, 32'd1);
      check({tag, "_pc"}, bus1.inst_pc, pc);
      check({tag, "_out"}, bus1.inst_out, ins);
   endtask

   initial begin
      reset = 1'b1;
      bus0.inst_ready     = 1'b1;
      bus0.redirect_valid = 1'b0;
      bus0.redirect_pc    = 32'd0;
      bus1.inst_ready     = 1'b1;
      bus1.redirect_valid = 1'b0;
      bus1.redirect_pc    = 32'd0;

      // Reset state.
      #1;
      check("rst_valid", {31'd0, bus0.inst_valid}, 32'd0);
      check("rst_en", {31'd0, bus0.imem_enable}, 32'd0);
      check("rst_out", bus0.inst_out, 32'd0);
      check("rst_pc", bus0.inst_pc, 32'd0);

      // Release mid-cycle: cycle 0 issues RESET_PC.
      #11;
      reset = 1'b0;
      #1;
      expect_issue("c0", 1'b1, 32'h0);
      check("c0_wrap_addr", bus1.imem_address, 32'hFFFF_FFF8);

      step(); #1;
      check("c1_valid", {31'd0, bus0.inst_valid}, 32'd0);
      expect_issue("c1", 1'b1, 32'h4);

      step(); #1;
      expect_head("c2", 32'h0, 32'h00E0_0093);
      expect_wrap("w2", 32'hFFFF_FFF8, 32'hA000_003E);
      step(); #1;
      expect_head("c3", 32'h4, 32'h0010_0113);
      expect_wrap("w3", 32'hFFFF_FFFC, 32'hA000_003F);
      step(); #1;
      expect_head("c4", 32'h8, 32'h0010_0193);
      expect_wrap("w4", 32'h0000_0000, 32'h00E0_0093);
      step(); #1;
      expect_head("c5", 32'hC, 32'h0010_0313);
      expect_wrap("w5", 32'h0000_0004, 32'h0010_0113);

      // Asynchronous reset between edges.
      step(); #1;
      check("pre_rst_valid", {31'd0, bus0.inst_valid}, 32'd1);
      reset = 1'b1;
      #1;
      check("arst_valid", {31'd0, bus0.inst_valid}, 32'd0);
      check("arst_en", {31'd0, bus0.imem_enable}, 32'd0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      expect_issue("rc0", 1'b1, 32'h0);

      // Stall from cycle 2.
      step(); #1;
      expect_issue("rc1", 1'b1, 32'h4);
      step();
      bus0.inst_ready = 1'b0;
      #1;
      expect_head("st2", 32'h0, 32'h00E0_0093);
      expect_issue("st2", 1'b0, 32'h0);
      step(); #1;
      expect_head("st3", 32'h0, 32'h00E0_0093);
      expect_issue("st3", 1'b0, 32'h0);
      step(); #1;
      expect_head("st4", 32'h0, 32'h00E0_0093);
      expect_issue("st4", 1'b0, 32'h0);
      step();
      bus0.inst_ready = 1'b1;
      #1;
      expect_head("st5", 32'h0, 32'h00E0_0093);
      expect_issue("st5", 1'b1, 32'h8);
      step(); #1;
      expect_head("st6", 32'h4, 32'h0010_0113);
      expect_issue("st6", 1'b1, 32'hC);

      // Redirect to 0x24 with an entry buffered and pc 0xC in flight.
      step();
      bus0.inst_ready     = 1'b0;
      bus0.redirect_valid = 1'b1;
      bus0.redirect_pc    = 32'h24;
      #1;
      expect_head("r0", 32'h8, 32'h0010_0193);
      expect_issue("r0", 1'b0, 32'h0);
      step();
      bus0.redirect_valid = 1'b0;
      bus0.inst_ready     = 1'b1;
      #1;
      check("r1_valid", {31'd0, bus0.inst_valid}, 32'd0);
      expect_issue("r1", 1'b1, 32'h24);
      step(); #1;
      check("r2_valid", {31'd0, bus0.inst_valid}, 32'd0);
      expect_issue("r2", 1'b1, 32'h28);

      // Misaligned redirect to 0x27 in the same cycle as the pop of 0x24.
      step();
      bus0.redirect_valid = 1'b1;
      bus0.redirect_pc    = 32'h27;
      #1;
      expect_head("r3", 32'h24, 32'hA000_0009);
      expect_issue("r3", 1'b0, 32'h0);
      step();
      bus0.redirect_valid = 1'b0;
      #1;
      check("m1_valid", {31'd0, bus0.inst_valid}, 32'd0);
      expect_issue("m1", 1'b1, 32'h24);
      step(); #1;
      check("m2_valid", {31'd0, bus0.inst_valid}, 32'd0);

      // Back-to-back redirects: 0x40 then 0x10; the last one wins.
      step();
      bus0.redirect_valid = 1'b1;
      bus0.redirect_pc    = 32'h40;
      #1;
      expect_head("m3", 32'h24, 32'hA000_0009);
      step();
      bus0.redirect_pc = 32'h10;
      #1;
      check("b1_valid", {31'd0, bus0.inst_valid}, 32'd0);
      expect_issue("b1", 1'b0, 32'h0);
      step();
      bus0.redirect_valid = 1'b0;
      #1;
      expect_issue("b2", 1'b1, 32'h10);
      step(); #1;
      check("b3_valid", {31'd0, bus0.inst_valid}, 32'd0);
      step(); #1;
      expect_head("b4", 32'h10, 32'hA000_0004);
      step(); #1;
      expect_head("b5", 32'h14, 32'hA000_0005);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
